matmult_result_drain: RTL and testbench

- Downstream neighbour of the matmult kernel: captures each kernel result word (C, Wr_en, Wr_addr) into an internal result buffer.
- Once every one of NUM_RES addresses has been written, streams the buffer out in address order over a valid/ready interface to the host/DMA side.
- Flags out-of-range and late writes; one full frame is buffered at a time.

---
 rtl/matmult_result_drain_pkg.sv | 38 +++
 rtl/matmult_result_drain_if.sv | 35 +++
 rtl/matmult_result_ram.sv | 32 +++
 rtl/matmult_result_drain.sv | 209 ++++++++++++++++++++
 tb/tb_matmult_result_drain.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmult_result_drain_pkg.sv
// rtl/matmult_result_drain_pkg.sv - shared constants and state encoding for the matmult result drain
//
// Purpose : default widths tied to the kernel's output-width / output-address-width
//           constants, frame size derived from the kernel execution-cycle count,
//           and the COLLECT/DRAIN state encoding.
// Ports   : none (package).
// Options : MATMULT_DRAIN_SAT_EN selects the saturated output width in the build.

package matmult_result_drain_pkg;

   // Kernel-side constants (mirrors of the existing define.v values)
   localparam int OUTPUT_W      = 32;
   localparam int OUTPUT_ADDR_W = 6;
   localparam int EXECYCLE      = 70;

   // Defaults for the drain block
   localparam int DATA_W_DEF  = OUTPUT_W;
   localparam int ADDR_W_DEF  = OUTPUT_ADDR_W;
   localparam int NUM_RES_DEF = EXECYCLE - 6;
   localparam int OUT_W_DEF   = 16;

`ifdef MATMULT_DRAIN_SAT_EN
   localparam int OUT_DATA_W_DEF = OUT_W_DEF;
`else
   localparam int OUT_DATA_W_DEF = DATA_W_DEF;
`endif

   typedef enum logic {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } drain_state_t;

   // Index width for NUM_RES-entry storage (never zero)
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/matmult_result_drain_if.sv
// rtl/matmult_result_drain_if.sv - kernel write interface and result stream interface
//
// Purpose : bundles the kernel result strobe (Wr_en/Wr_addr/C) and the outgoing
//           valid/ready result stream (Out_valid/Out_ready/Out_data/Out_last).
// matmult_result_wr_if    : master = kernel (drives Wr_en, Wr_addr, C), slave = drain.
// matmult_result_drain_if : master = drain (drives Out_valid, Out_data, Out_last),
//                           slave = host/DMA (drives Out_ready).

interface matmult_result_wr_if
   import matmult_result_drain_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) ();
   logic              Wr_en;
   logic [ADDR_W-1:0] Wr_addr;
   logic [DATA_W-1:0] C;

   modport master (output Wr_en, Wr_addr, C);
   modport slave  (input  Wr_en, Wr_addr, C);
endinterface

interface matmult_result_drain_if
   import matmult_result_drain_pkg::*;
#(
   parameter int DATA_W = OUT_DATA_W_DEF
) ();
   logic              Out_valid;
   logic              Out_ready;
   logic [DATA_W-1:0] Out_data;
   logic              Out_last;

   modport master (output Out_valid, Out_data, Out_last, input  Out_ready);
   modport slave  (input  Out_valid, Out_data, Out_last, output Out_ready);
endinterface

// File: rtl/matmult_result_ram.sv
// rtl/matmult_result_ram.sv - simple dual-port result buffer with synchronous read
//
// Purpose : DEPTH x DATA_W storage, one write port and one registered read port.
//           The array and the read register carry no reset.
// Ports   : clk (rising edge), we/wa/wd write port, ra read address,
//           rd read data (registered, valid one edge after ra).

module matmult_result_ram
   import matmult_result_drain_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = NUM_RES_DEF,
   parameter int AW     = idx_width(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [AW-1:0]     ra,
   output logic [DATA_W-1:0] rd
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= wd;
      end
      rd <= mem[ra];
   end

endmodule

// File: rtl/matmult_result_drain.sv
// rtl/matmult_result_drain.sv - buffers one frame of kernel results and streams it out in order
//
// Purpose : collects NUM_RES result words by address, then drains them in address
//           order over a valid/ready stream; flags out-of-range and late writes.
// Ports   : Clk, Rst (async, active high)
//           wr  (matmult_result_wr_if.slave)    : Wr_en, Wr_addr, C from the kernel
//           out (matmult_result_drain_if.master): Out_valid, Out_ready, Out_data, Out_last
//           Clr_flags in  : synchronous clear of the sticky flags
//           Busy      out : high while draining
//           Err_addr  out : sticky, write with Wr_addr >= NUM_RES
//           Err_overrun out : sticky, write dropped because the frame was draining
// Options : MATMULT_DRAIN_SAT_EN - Out_data becomes OUT_W bits, signed-saturated.

module matmult_result_drain
   import matmult_result_drain_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
`ifdef MATMULT_DRAIN_SAT_EN
   parameter int OUT_W   = OUT_W_DEF,
`endif
   parameter int NUM_RES = NUM_RES_DEF
) (
   input  logic                  Clk,
   input  logic                  Rst,
   matmult_result_wr_if.slave    wr,
   matmult_result_drain_if.master out,
   input  logic                  Clr_flags,
   output logic                  Busy,
   output logic                  Err_addr,
   output logic                  Err_overrun
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int IDX_W = idx_width(NUM_RES);

   drain_state_t      state, state_nxt;
   logic [CNT_W-1:0]  fill_cnt;
   logic [NUM_RES-1:0] vbits;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] rd_addr;
   logic              out_valid;
   logic              last_word;
   logic [DATA_W-1:0] rd_data;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;

   logic in_range;
   logic wr_store;
   logic wr_new;
   logic fill_done;
   logic hs;
   logic last_hs;
   logic err_addr_set;
   logic err_ovr_set;

   // ---------------------------------------------------------------
   // Write decode and handshake
   // ---------------------------------------------------------------
   always_comb begin
      in_range  = ({1'b0, wr.Wr_addr} < CNT_W'(NUM_RES));
      wr_idx    = wr.Wr_addr[IDX_W-1:0];
      wr_new    = wr_store && !vbits[wr_idx];
      fill_done = wr_new && (fill_cnt == CNT_W'(NUM_RES - 1));
      last_word = out_valid && (rd_ptr == ADDR_W'(NUM_RES - 1));
      hs        = out_valid && out.Out_ready;
      last_hs   = hs && last_word;
      // Prefetch the next word on a handshake so the stream has no bubble;
      // after the final word the pointer is not advanced past the frame.
      rd_addr   = (hs && !last_word) ? rd_ptr + ADDR_W'(1) : rd_ptr;
      rd_idx    = rd_addr[IDX_W-1:0];
   end

   // ---------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ---------------------------------------------------------------
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= COLLECT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (fill_done) state_nxt = DRAIN;
         DRAIN:   if (last_hs)   state_nxt = COLLECT;
         default:                state_nxt = COLLECT;
      endcase
   end

   always_comb begin
      Busy         = 1'b0;
      wr_store     = 1'b0;
      err_addr_set = 1'b0;
      err_ovr_set  = 1'b0;
      case (state)
         COLLECT: begin
            wr_store     = wr.Wr_en && in_range;
            err_addr_set = wr.Wr_en && !in_range;
         end
         DRAIN: begin
            Busy        = 1'b1;
            // Covers the final-handshake cycle too: the frame is still draining.
            err_ovr_set = wr.Wr_en;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------
   // Fill tracking and read pointer
   // ---------------------------------------------------------------
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         fill_cnt  <= '0;
         vbits     <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               out_valid <= 1'b0;
               rd_ptr    <= '0;
               if (wr_new) begin
                  vbits[wr_idx] <= 1'b1;
                  fill_cnt      <= fill_cnt + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (last_hs) begin
                  out_valid <= 1'b0;
                  rd_ptr    <= '0;
                  fill_cnt  <= '0;
                  vbits     <= '0;
               end else begin
                  // First DRAIN cycle issues the read of word 0; valid follows.
                  out_valid <= 1'b1;
                  if (hs) begin
                     rd_ptr <= rd_ptr + ADDR_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Sticky flags: a new error wins over a simultaneous clear
   // ---------------------------------------------------------------
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Err_addr    <= 1'b0;
         Err_overrun <= 1'b0;
      end else begin
         if (err_addr_set)   Err_addr <= 1'b1;
         else if (Clr_flags) Err_addr <= 1'b0;
         if (err_ovr_set)    Err_overrun <= 1'b1;
         else if (Clr_flags) Err_overrun <= 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Result buffer
   // ---------------------------------------------------------------
   matmult_result_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (NUM_RES),
      .AW     (IDX_W)
   ) u_ram (
      .clk (Clk),
      .we  (wr_store),
      .wa  (wr_idx),
      .wd  (wr.C),
      .ra  (rd_idx),
      .rd  (rd_data)
   );

   // ---------------------------------------------------------------
   // Output stream; data is forced to zero whenever nothing is presented
   // ---------------------------------------------------------------
   assign out.Out_valid = out_valid;
   assign out.Out_last  = last_word;

`ifdef MATMULT_DRAIN_SAT_EN
   localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [DATA_W-1:0] SAT_MIN = ~SAT_MAX;

   logic [OUT_W-1:0] sat_data;

   always_comb begin
      if ($signed(rd_data) > SAT_MAX) begin
         sat_data = {1'b0, {(OUT_W - 1){1'b1}}};
      end else if ($signed(rd_data) < SAT_MIN) begin
         sat_data = {1'b1, {(OUT_W - 1){1'b0}}};
      end else begin
         sat_data = rd_data[OUT_W-1:0];
      end
   end

   assign out.Out_data = out_valid ? sat_data : '0;
`else
   assign out.Out_data = out_valid ? rd_data : '0;
`endif

endmodule

// File: tb/tb_matmult_result_drain.sv
// tb/tb_matmult_result_drain.sv - self-checking bench for matmult_result_drain
//
// Purpose : random frames checked against an address-indexed reference buffer;
//           covers reset, fill/drain, backpressure, duplicates, out-of-range,
//           overrun, async reset mid-drain and (with MATMULT_DRAIN_SAT_EN) saturation.

module tb_matmult_result_drain;
   import matmult_result_drain_pkg::*;

   localparam int DW = 32;
   localparam int AW = 7;
   localparam int NR = 64;
`ifdef MATMULT_DRAIN_SAT_EN
   localparam int OW = 16;
`else
   localparam int OW = DW;
`endif

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   logic Clr_flags = 1'b0;
   logic Busy, Err_addr, Err_overrun;

   matmult_result_wr_if #(.DATA_W(DW), .ADDR_W(AW)) wr_if ();
   matmult_result_drain_if #(.DATA_W(OW)) out_if ();

   matmult_result_drain #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
`ifdef MATMULT_DRAIN_SAT_EN
      .OUT_W   (OW),
`endif
      .NUM_RES (NR)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .wr          (wr_if),
      .out         (out_if),
      .Clr_flags   (Clr_flags),
      .Busy        (Busy),
      .Err_addr    (Err_addr),
      .Err_overrun (Err_overrun)
   );

   always #5 Clk = ~Clk;

   int     checks = 0;
   int     errors = 0;
   longint model_mem [NR];
   longint got_data  [NR];
   bit     got_last  [NR];

   // Reference: what the consumer must see for a stored word
   function automatic longint exp_out(input longint c);
      longint lim;
      lim = longint'(1) <<< (OW - 1);
      if (c >= lim)  return lim - 1;
      if (c < -lim)  return -lim;
      return c;
   endfunction

   function automatic longint cur_data();
      return longint'($signed(out_if.Out_data));
   endfunction

   task automatic write_word(input int addr, input longint data);
      wr_if.Wr_en   = 1'b1;
      wr_if.Wr_addr = addr[AW-1:0];
      wr_if.C       = data[DW-1:0];
      if (addr < NR) model_mem[addr] = data;
      @(posedge Clk); #1;
      wr_if.Wr_en = 1'b0;
   endtask

   // Writes every address except skip_a/skip_b, random order, random data
   task automatic write_frame(input int skip_a, input int skip_b);
      int     order [NR];
      int     j, t;
      longint d;
      for (int i = 0; i < NR; i++) order[i] = i;
      for (int i = NR - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < NR; i++) begin
         if (order[i] != skip_a && order[i] != skip_b) begin
            if ($urandom_range(0, 1) == 1) d = longint'($signed($urandom()));
            else d = longint'($urandom_range(0, 80000)) - 40000;
            write_word(order[i], d);
         end
      end
   endtask

   // Consumes up to max_words; mode 0 ready=1, 1 pattern 1,0,0, 2 random.
   // Optionally drives one write at stream cycle inj_cyc. Records observations only.
   task automatic collect(input int max_words, input int mode, input int inj_cyc,
                          input int inj_addr, input longint inj_data,
                          output int n_got, output int held_bad, output int cycles);
      int     cyc = 0;
      int     budget = 0;
      bit     started = 0;
      bit     prev_stall = 0;
      longint prev_d = 0;
      bit     prev_l = 0;
      bit     rdy;
      n_got = 0; held_bad = 0;
      while (n_got < max_words && budget < 3000) begin
         if (out_if.Out_valid === 1'b1) started = 1;
         if (!started) rdy = 0;
         else if (mode == 0) rdy = 1;
         else if (mode == 1) rdy = (cyc % 3 == 0);
         else rdy = $urandom_range(0, 1) == 1;
         out_if.Out_ready = rdy;
         if (started && cyc == inj_cyc) begin
            wr_if.Wr_en   = 1'b1;
            wr_if.Wr_addr = inj_addr[AW-1:0];
            wr_if.C       = inj_data[DW-1:0];
         end
         if (prev_stall && (out_if.Out_valid !== 1'b1 || cur_data() != prev_d ||
                            out_if.Out_last !== prev_l)) held_bad++;
         if (out_if.Out_valid === 1'b1 && rdy) begin
            got_data[n_got] = cur_data();
            got_last[n_got] = out_if.Out_last;
            n_got++;
         end
         prev_stall = started && out_if.Out_valid === 1'b1 && !rdy;
         prev_d = cur_data();
         prev_l = out_if.Out_last;
         if (started) cyc++;
         budget++;
         @(posedge Clk); #1;
         wr_if.Wr_en = 1'b0;
      end
      out_if.Out_ready = 1'b0;
      cycles = cyc;
   endtask

   task automatic test_reset();
      checks++; if (out_if.Out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_if.Out_valid); end
      checks++; if (out_if.Out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", out_if.Out_last); end
      checks++; if (out_if.Out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_if.Out_data); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
      checks++; if (Err_addr !== 1'b0) begin errors++; $display("FAIL reset_err_addr: got %b want 0", Err_addr); end
      checks++; if (Err_overrun !== 1'b0) begin errors++; $display("FAIL reset_err_overrun: got %b want 0", Err_overrun); end
      Rst = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic test_fill_drain();
      int n, hb, cy;
      for (int i = 0; i < NR; i++) write_word(i, longint'(i * 3 - 100));
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL fill_busy: got %b want 1", Busy); end
      checks++; if (out_if.Out_valid !== 1'b0) begin errors++; $display("FAIL fill_early_valid: got %b want 0", out_if.Out_valid); end
      @(posedge Clk); #1;
      checks++; if (out_if.Out_valid !== 1'b1 || cur_data() != -100) begin
         errors++; $display("FAIL fill_latency: valid %b data %0d want 1 -100", out_if.Out_valid, cur_data()); end
      collect(NR, 0, -1, 0, 0, n, hb, cy);
      checks++; if (n != NR) begin errors++; $display("FAIL fill_count: got %0d want %0d", n, NR); end
      checks++; if (cy != NR) begin errors++; $display("FAIL fill_gaps: cycles %0d want %0d", cy, NR); end
      for (int i = 0; i < n; i++) begin
         checks++; if (got_data[i] != exp_out(i * 3 - 100)) begin errors++; $display("FAIL fill_word %0d: got %0d want %0d", i, got_data[i], exp_out(i * 3 - 100)); end
         checks++; if (got_last[i] != (i == NR - 1)) begin errors++; $display("FAIL fill_last %0d: got %b want %b", i, got_last[i], i == NR - 1); end
      end
      checks++; if (Busy !== 1'b0 || out_if.Out_valid !== 1'b0) begin
         errors++; $display("FAIL fill_end: busy %b valid %b want 0 0", Busy, out_if.Out_valid); end
   endtask

   task automatic test_backpressure();
      int n, hb, cy;
      write_frame(-1, -1);
      collect(NR, 1, -1, 0, 0, n, hb, cy);
      checks++; if (n != NR) begin errors++; $display("FAIL bp_count: got %0d want %0d", n, NR); end
      checks++; if (hb != 0) begin errors++; $display("FAIL bp_held: unstable cycles %0d want 0", hb); end
      for (int i = 0; i < n; i++) begin
         checks++; if (got_data[i] != exp_out(model_mem[i]) || got_last[i] != (i == NR - 1)) begin
            errors++; $display("FAIL bp_word %0d: got %0d/%b want %0d/%b", i, got_data[i], got_last[i], exp_out(model_mem[i]), i == NR - 1); end
      end
   endtask

   task automatic test_dup_oor();
      int n, hb, cy;
      write_word(5, 7);
      write_word(70, 12345);
      checks++; if (Err_addr !== 1'b1) begin errors++; $display("FAIL oor_flag: got %b want 1", Err_addr); end
      Clr_flags = 1'b1;
      write_word(100, 1);
      Clr_flags = 1'b0;
      checks++; if (Err_addr !== 1'b1) begin errors++; $display("FAIL oor_clr_priority: got %b want 1", Err_addr); end
      Clr_flags = 1'b1;
      @(posedge Clk); #1;
      Clr_flags = 1'b0;
      checks++; if (Err_addr !== 1'b0) begin errors++; $display("FAIL oor_clr: got %b want 0", Err_addr); end
      write_frame(5, 63);
      write_word(5, 9);
      repeat (3) @(posedge Clk);
      #1;
      checks++; if (Busy !== 1'b0 || out_if.Out_valid !== 1'b0) begin
         errors++; $display("FAIL dup_early_drain: busy %b valid %b want 0 0", Busy, out_if.Out_valid); end
      write_word(63, longint'($urandom_range(0, 1000)));
      collect(NR, 2, -1, 0, 0, n, hb, cy);
      checks++; if (n != NR || hb != 0) begin errors++; $display("FAIL dup_count: got %0d held %0d want %0d 0", n, hb, NR); end
      checks++; if (got_data[5] != 9) begin errors++; $display("FAIL dup_word5: got %0d want 9", got_data[5]); end
      for (int i = 0; i < n; i++) begin
         checks++; if (got_data[i] != exp_out(model_mem[i])) begin errors++; $display("FAIL dup_word %0d: got %0d want %0d", i, got_data[i], exp_out(model_mem[i])); end
      end
      checks++; if (Err_overrun !== 1'b0) begin errors++; $display("FAIL dup_no_overrun: got %b want 0", Err_overrun); end
   endtask

   task automatic test_overrun();
      int     n, hb, cy;
      longint orig3;
      write_frame(-1, -1);
      orig3 = model_mem[3];
      collect(NR, 0, 1, 3, 1234, n, hb, cy);
      checks++; if (Err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", Err_overrun); end
      checks++; if (n != NR || got_data[3] != exp_out(orig3)) begin errors++; $display("FAIL ovr_word3: got %0d want %0d", got_data[3], exp_out(orig3)); end
      for (int i = 0; i < n; i++) begin
         checks++; if (got_data[i] != exp_out(model_mem[i])) begin errors++; $display("FAIL ovr_word %0d: got %0d want %0d", i, got_data[i], exp_out(model_mem[i])); end
      end
      Clr_flags = 1'b1;
      @(posedge Clk); #1;
      Clr_flags = 1'b0;
      checks++; if (Err_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", Err_overrun); end
      // write landing on the final handshake must be dropped, not start the next frame
      write_frame(-1, -1);
      collect(NR, 0, NR - 1, 3, 555, n, hb, cy);
      checks++; if (Err_overrun !== 1'b1 || n != NR) begin errors++; $display("FAIL ovr_last_flag: flag %b count %0d want 1 %0d", Err_overrun, n, NR); end
      Clr_flags = 1'b1;
      @(posedge Clk); #1;
      Clr_flags = 1'b0;
      write_frame(3, -1);
      repeat (3) @(posedge Clk);
      #1;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ovr_last_leak: busy %b want 0", Busy); end
      write_word(3, -77);
      collect(NR, 0, -1, 0, 0, n, hb, cy);
      checks++; if (n != NR || got_data[3] != -77) begin errors++; $display("FAIL ovr_next_frame: count %0d word3 %0d want %0d -77", n, got_data[3], NR); end
   endtask

   task automatic test_async_reset();
      int n, hb, cy;
      write_frame(-1, -1);
      collect(10, 0, -1, 0, 0, n, hb, cy);
      for (int i = 0; i < 10; i++) begin
         checks++; if (got_data[i] != exp_out(model_mem[i])) begin errors++; $display("FAIL rst_pre_word %0d: got %0d want %0d", i, got_data[i], exp_out(model_mem[i])); end
      end
      #2 Rst = 1'b1;
      #1;
      checks++; if (out_if.Out_valid !== 1'b0 || Busy !== 1'b0 || out_if.Out_data !== '0) begin
         errors++; $display("FAIL rst_async: valid %b busy %b data %h want 0 0 0", out_if.Out_valid, Busy, out_if.Out_data); end
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(posedge Clk); #1;
      write_frame(-1, -1);
      collect(NR, 2, -1, 0, 0, n, hb, cy);
      checks++; if (n != NR) begin errors++; $display("FAIL rst_new_count: got %0d want %0d", n, NR); end
      for (int i = 0; i < n; i++) begin
         checks++; if (got_data[i] != exp_out(model_mem[i]) || got_last[i] != (i == NR - 1)) begin
            errors++; $display("FAIL rst_new_word %0d: got %0d/%b want %0d/%b", i, got_data[i], got_last[i], exp_out(model_mem[i]), i == NR - 1); end
      end
   endtask

   task automatic test_back_to_back();
      int n, hb, cy;
      for (int f = 0; f < 2; f++) begin
         write_frame(-1, -1);
         collect(NR, 2, -1, 0, 0, n, hb, cy);
         checks++; if (n != NR || hb != 0) begin errors++; $display("FAIL b2b_count f%0d: got %0d held %0d want %0d 0", f, n, hb, NR); end
         for (int i = 0; i < n; i++) begin
            checks++; if (got_data[i] != exp_out(model_mem[i])) begin errors++; $display("FAIL b2b_word f%0d %0d: got %0d want %0d", f, i, got_data[i], exp_out(model_mem[i])); end
         end
      end
   endtask

`ifdef MATMULT_DRAIN_SAT_EN
   task automatic test_saturation();
      int n, hb, cy;
      write_word(0, 40000);
      write_word(1, -40000);
      write_word(2, -5);
      for (int i = 3; i < NR; i++) write_word(i, longint'(i));
      collect(NR, 0, -1, 0, 0, n, hb, cy);
      checks++; if (got_data[0] != 32767) begin errors++; $display("FAIL sat_pos: got %0d want 32767", got_data[0]); end
      checks++; if (got_data[1] != -32768) begin errors++; $display("FAIL sat_neg: got %0d want -32768", got_data[1]); end
      checks++; if (got_data[2] != -5) begin errors++; $display("FAIL sat_pass: got %0d want -5", got_data[2]); end
   endtask
`endif

   initial begin
      wr_if.Wr_en      = 1'b0;
      wr_if.Wr_addr    = '0;
      wr_if.C          = '0;
      out_if.Out_ready = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      test_reset();
      test_fill_drain();
      test_backpressure();
      test_dup_oor();
      test_overrun();
      test_async_reset();
      test_back_to_back();
`ifdef MATMULT_DRAIN_SAT_EN
      test_saturation();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
